// File: rtl/time_set_ctrl.sv
// HH:MM clock controller: BCD hour/minute registers, minute tick advance,
// debounced mode/increment buttons and blink flags for the field being set.
//
// state  | meaning
// RUN    | time advances on tick_1min, inc press ignored
// SET_H  | inc press advances hour 23->00, ticks dropped, hour digits blink
// SET_M  | inc press advances minute 59->00 (no hour carry), minute digits blink
module time_set_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int BLINK_CYCLES = 25
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1min,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic [3:0] hr10,
  output logic [3:0] hr1,
  output logic [3:0] mn10,
  output logic [3:0] mn1,
  output logic       blank_h,
  output logic       blank_m
);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SET_H = 2'b01;
  localparam logic [1:0] MODE_SET_M = 2'b10;

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

  // Button channel 0 is mode, channel 1 is increment.
  logic [1:0]            btn_raw;
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            deb;
  logic [1:0]            deb_d;
  logic [1:0][DEB_W-1:0] deb_cnt;
  logic                  press_mode;
  logic                  press_inc;

  assign btn_raw    = {btn_inc, btn_mode};
  assign press_mode = deb[0] & ~deb_d[0];
  assign press_inc  = deb[1] & ~deb_d[1];

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_d   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Increment helpers saturate-wrap on any digit at or above its limit.
  function automatic logic [8:0] min_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [8:0] r;
    if (ones >= 4'd9) begin
      if (tens >= 4'd5) r = {1'b1, 4'd0, 4'd0};
      else              r = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      r = {1'b0, tens, ones + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] hour_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (tens >= 4'd2 && ones >= 4'd3) r = 8'h00;
    else if (ones >= 4'd9)            r = {tens + 4'd1, 4'd0};
    else                              r = {tens, ones + 4'd1};
    return r;
  endfunction

  logic [8:0] min_next;
  logic [7:0] hr_next;

  assign min_next = min_inc(mn10, mn1);
  assign hr_next  = hour_inc(hr10, hr1);

  logic [1:0]         mode_nxt;
  logic [3:0]         hr10_nxt;
  logic [3:0]         hr1_nxt;
  logic [3:0]         mn10_nxt;
  logic [3:0]         mn1_nxt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_nxt;
  logic               phase;
  logic               phase_nxt;

  // The current state's action is applied before any mode change.
  always_comb begin
    mode_nxt = mode;
    hr10_nxt = hr10;
    hr1_nxt  = hr1;
    mn10_nxt = mn10;
    mn1_nxt  = mn1;
    case (mode)
      MODE_RUN: begin
        if (tick_1min) begin
          {mn10_nxt, mn1_nxt} = min_next[7:0];
          if (min_next[8]) {hr10_nxt, hr1_nxt} = hr_next;
        end
        if (press_mode) mode_nxt = MODE_SET_H;
      end
      MODE_SET_H: begin
        if (press_inc)  {hr10_nxt, hr1_nxt} = hr_next;
        if (press_mode) mode_nxt = MODE_SET_M;
      end
      MODE_SET_M: begin
        if (press_inc)  {mn10_nxt, mn1_nxt} = min_next[7:0];
        if (press_mode) mode_nxt = MODE_RUN;
      end
      default: mode_nxt = MODE_RUN;
    endcase
  end

  always_comb begin
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    if (mode_nxt == MODE_RUN || mode_nxt != mode) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end else begin
      blink_cnt_nxt = blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      mode      <= MODE_RUN;
      hr10      <= 4'd0;
      hr1       <= 4'd0;
      mn10      <= 4'd0;
      mn1       <= 4'd0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      blank_h   <= 1'b0;
      blank_m   <= 1'b0;
    end else begin
      mode      <= mode_nxt;
      hr10      <= hr10_nxt;
      hr1       <= hr1_nxt;
      mn10      <= mn10_nxt;
      mn1       <= mn1_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      blank_h   <= (mode_nxt == MODE_SET_H) & phase_nxt;
      blank_m   <= (mode_nxt == MODE_SET_M) & phase_nxt;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: reset, minute carries, set modes,
// debounce latency, simultaneous events and blink timing.
module tb_time_set_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       tick_1min;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] mode;
  logic [3:0] hr10, hr1, mn10, mn1;
  logic       blank_h, blank_m;

  int n_chk  = 0;
  int n_fail = 0;

  time_set_ctrl #(.DEB_CYCLES(4), .BLINK_CYCLES(25)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_1min (tick_1min),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .mode      (mode),
    .hr10      (hr10),
    .hr1       (hr1),
    .mn10      (mn10),
    .mn1       (mn1),
    .blank_h   (blank_h),
    .blank_m   (blank_m)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    tick_1min = 1'b1;
    step(n);
    tick_1min = 1'b0;
  endtask

  // Effect lands on the 7th edge; the low tail lets the debouncer settle.
  task automatic press(input bit sel_inc);
    if (sel_inc) btn_inc = 1'b1; else btn_mode = 1'b1;
    step(7);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    step(8);
  endtask

  function automatic logic [15:0] cur_time();
    return {hr10, hr1, mn10, mn1};
  endfunction

  initial begin
    rst = 1'b0; tick_1min = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    #1;
    // Reset held two edges while buttons toggle.
    btn_mode = 1'b1; step(1);
    btn_mode = 1'b0; btn_inc = 1'b1; step(1);
    chk("rst_mode", {14'd0, mode}, 16'h0000);
    chk("rst_time", cur_time(), 16'h0000);
    chk("rst_blank", {14'd0, blank_h, blank_m}, 16'h0000);
    btn_inc = 1'b0; rst = 1'b1;
    step(12);
    chk("post_rst_mode", {14'd0, mode}, 16'h0000);
    chk("post_rst_time", cur_time(), 16'h0000);

    // RUN carries.
    tick_n(599);  chk("t_0959", cur_time(), 16'h0959);
    tick_n(1);    chk("t_1000", cur_time(), 16'h1000);
    tick_n(839);  chk("t_2359", cur_time(), 16'h2359);
    tick_n(1);    chk("t_0000", cur_time(), 16'h0000);
    tick_n(754);  chk("t_1234", cur_time(), 16'h1234);
    press(1'b1);
    chk("run_inc_time", cur_time(), 16'h1234);
    chk("run_inc_mode", {14'd0, mode}, 16'h0000);

    // SET_H.
    press(1'b0);
    chk("seth_mode", {14'd0, mode}, 16'h0001);
    repeat (10) press(1'b1);
    chk("seth_22", cur_time(), 16'h2234);
    tick_n(5);
    chk("seth_tick_drop", cur_time(), 16'h2234);
    press(1'b1); chk("seth_23", cur_time(), 16'h2334);
    press(1'b1); chk("seth_00", cur_time(), 16'h0034);
    press(1'b1); chk("seth_01", cur_time(), 16'h0134);

    // Debounce: 3-cycle glitch ignored, held press lands on edge 7 once.
    btn_inc = 1'b1; step(3);
    btn_inc = 1'b0; step(10);
    chk("glitch", cur_time(), 16'h0134);
    btn_inc = 1'b1; step(6);
    chk("edge6", cur_time(), 16'h0134);
    step(1);
    chk("edge7", cur_time(), 16'h0234);
    step(20);
    chk("no_repeat", cur_time(), 16'h0234);
    btn_inc = 1'b0; step(8);

    // SET_M wrap without hour carry.
    press(1'b0);
    chk("setm_mode", {14'd0, mode}, 16'h0002);
    repeat (25) press(1'b1);
    chk("setm_59", cur_time(), 16'h0259);
    press(1'b1);
    chk("setm_00", cur_time(), 16'h0200);
    press(1'b0);
    chk("back_run", {14'd0, mode}, 16'h0000);

    // Tick and mode press in the same cycle.
    btn_mode = 1'b1; step(6);
    tick_1min = 1'b1; step(1);
    tick_1min = 1'b0; btn_mode = 1'b0;
    chk("sim_mode", {14'd0, mode}, 16'h0001);
    chk("sim_time", cur_time(), 16'h0201);

    // Blink from entry sample: 25 visible, 25 blanked, then visible.
    for (int i = 0; i < 51; i++) begin
      chk($sformatf("blank_h_%0d", i), {15'd0, blank_h}, {15'd0, (i >= 25 && i < 50)});
      if (i % 10 == 0) chk("blank_m_in_seth", {15'd0, blank_m}, 16'h0000);
      step(1);
    end

    // Reset mid-SET_M.
    press(1'b0);
    chk("setm2_mode", {14'd0, mode}, 16'h0002);
    step(20);
    chk("setm2_blank_m", {15'd0, blank_m}, 16'h0001);
    chk("setm2_blank_h", {15'd0, blank_h}, 16'h0000);
    rst = 1'b0; step(1); rst = 1'b1;
    chk("rst2_mode", {14'd0, mode}, 16'h0000);
    chk("rst2_time", cur_time(), 16'h0000);
    chk("rst2_blank", {14'd0, blank_h, blank_m}, 16'h0000);
    step(5);
    chk("rst2_hold", {14'd0, mode}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
